// File: rtl/disp_share_arb_pkg.sv
// Shared definitions for the display-sharing arbiter: requester count, FSM encoding,
// digit width and the blank decimal-point pattern.
package disp_share_arb_pkg;

  localparam int unsigned NReq   = 4;
  localparam int unsigned IdxW   = 2;
  localparam int unsigned DigitW = 4;

  // Decimal points are active-low, so all-ones means every dp is off.
  localparam logic [3:0] DpOff = 4'b1111;

  typedef enum logic {
    StIdle = 1'b0,
    StShow = 1'b1
  } state_e;

  function automatic logic [NReq-1:0] onehot(input logic [IdxW-1:0] idx);
    logic [NReq-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/disp_share_arb_rr_pick.sv
// Combinational round-robin selector: first requester (not excluded) searching
// ptr+1, ptr+2, ... ptr+NReq, wrapping modulo NReq.
module disp_share_arb_rr_pick
  import disp_share_arb_pkg::*;
(
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  input  logic [NReq-1:0] exclude_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  // Scan candidates in rotating order and latch the first eligible one.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    for (int unsigned i = 1; i <= NReq; i++) begin
      cand = ptr_i + IdxW'(i);
      if (!valid_o && req_i[cand] && !exclude_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/disp_share_arb.sv
// Round-robin arbiter sharing one 4-digit 7-segment display among four requesters.
// The winner is held for at least Dwell cycles while it keeps requesting; gnt, digits,
// dp and blank are all registered and change on the same edge.
module disp_share_arb
  import disp_share_arb_pkg::*;
#(
  parameter int unsigned Dwell = 50_000_000,
  parameter int unsigned CntW  = 26
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NReq-1:0]   req_i,
  input  logic [15:0]       data0_i,
  input  logic [15:0]       data1_i,
  input  logic [15:0]       data2_i,
  input  logic [15:0]       data3_i,
  input  logic [3:0]        dp0_i,
  input  logic [3:0]        dp1_i,
  input  logic [3:0]        dp2_i,
  input  logic [3:0]        dp3_i,
  output logic [NReq-1:0]   gnt_o,
  output logic [DigitW-1:0] hex3_o,
  output logic [DigitW-1:0] hex2_o,
  output logic [DigitW-1:0] hex1_o,
  output logic [DigitW-1:0] hex0_o,
  output logic [3:0]        dp_out_o,
  output logic              blank_o
);

  localparam logic [CntW-1:0] CntLoad = CntW'(Dwell - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NReq-1:0] gnt_q, gnt_d;
  logic [15:0]     hex_q, hex_d;
  logic [3:0]      dp_q, dp_d;
  logic            blank_q, blank_d;

  logic [15:0]     data_arr [NReq];
  logic [3:0]      dp_arr   [NReq];

  logic [NReq-1:0] excl;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic            repick;

  assign data_arr[0] = data0_i;
  assign data_arr[1] = data1_i;
  assign data_arr[2] = data2_i;
  assign data_arr[3] = data3_i;
  assign dp_arr[0]   = dp0_i;
  assign dp_arr[1]   = dp1_i;
  assign dp_arr[2]   = dp2_i;
  assign dp_arr[3]   = dp3_i;

  disp_share_arb_rr_pick u_rr_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .exclude_i (excl),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  // Next-state: hold the grant while it is requested and dwelling, otherwise re-pick.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    excl    = '0;
    repick  = 1'b0;

    unique case (state_q)
      StIdle: repick = 1'b1;
      StShow: begin
        if (!req_i[idx_q]) begin
          // Owner withdrew early: hand over to the remaining requesters.
          excl   = onehot(idx_q);
          repick = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Dwell expired: full rotation from ptr+1, owner last.
          repick = 1'b1;
        end
      end
      default: repick = 1'b1;
    endcase

    if (repick) begin
      if (pick_valid) begin
        state_d = StShow;
        idx_d   = pick_idx;
        ptr_d   = pick_idx;
        cnt_d   = CntLoad;
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    end
  end

  // Output next-state derived from the next grant so everything moves on one edge.
  always_comb begin
    if (state_d == StShow) begin
      gnt_d   = onehot(idx_d);
      hex_d   = data_arr[idx_d];
      dp_d    = dp_arr[idx_d];
      blank_d = 1'b0;
    end else begin
      gnt_d   = '0;
      hex_d   = '0;
      dp_d    = DpOff;
      blank_d = 1'b1;
    end
  end

  // State and registered outputs; reset points ptr at 3 so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      ptr_q   <= IdxW'(NReq - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      hex_q   <= '0;
      dp_q    <= DpOff;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      blank_q <= blank_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign hex3_o   = hex_q[15:12];
  assign hex2_o   = hex_q[11:8];
  assign hex1_o   = hex_q[7:4];
  assign hex0_o   = hex_q[3:0];
  assign dp_out_o = dp_q;
  assign blank_o  = blank_q;

endmodule

// File: tb/tb_disp_share_arb.sv
// Directed bench for disp_share_arb with Dwell=4.
module tb_disp_share_arb;

  logic        clk;
  logic        rst_ni;
  logic [3:0]  req;
  logic [15:0] data0, data1, data2, data3;
  logic [3:0]  dp0, dp1, dp2, dp3;
  logic [3:0]  gnt;
  logic [3:0]  hex3, hex2, hex1, hex0;
  logic [3:0]  dp_out;
  logic        blank;

  int vectors = 0;
  int errs    = 0;

  disp_share_arb #(
    .Dwell (4),
    .CntW  (3)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .req_i    (req),
    .data0_i  (data0),
    .data1_i  (data1),
    .data2_i  (data2),
    .data3_i  (data3),
    .dp0_i    (dp0),
    .dp1_i    (dp1),
    .dp2_i    (dp2),
    .dp3_i    (dp3),
    .gnt_o    (gnt),
    .hex3_o   (hex3),
    .hex2_o   (hex2),
    .hex1_o   (hex1),
    .hex0_o   (hex0),
    .dp_out_o (dp_out),
    .blank_o  (blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [15:0] e_hex,
                         input logic [3:0] e_dp, input logic e_blank);
    chk({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    chk({tag, ".hex"}, 32'({hex3, hex2, hex1, hex0}), 32'(e_hex));
    chk({tag, ".dp"}, 32'(dp_out), 32'(e_dp));
    chk({tag, ".blank"}, 32'(blank), 32'(e_blank));
  endtask

  logic [15:0] d_tab [4];
  logic [3:0]  p_tab [4];

  initial begin
    d_tab[0] = 16'h1234; d_tab[1] = 16'h5678; d_tab[2] = 16'h9abc; d_tab[3] = 16'hdef0;
    p_tab[0] = 4'b1011;  p_tab[1] = 4'b0111;  p_tab[2] = 4'b1101;  p_tab[3] = 4'b1110;
    data0 = d_tab[0]; data1 = d_tab[1]; data2 = d_tab[2]; data3 = d_tab[3];
    dp0 = p_tab[0]; dp1 = p_tab[1]; dp2 = p_tab[2]; dp3 = p_tab[3];
    req    = 4'b0000;
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #1;

    // 1: reset values, then idle with no requests.
    chk_all("rst", 4'b0000, 16'h0000, 4'b1111, 1'b1);
    step();
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("idle", 4'b0000, 16'h0000, 4'b1111, 1'b1);
    end

    // 2: single request, one-cycle latency.
    req = 4'b0001;
    step();
    chk_all("first", 4'b0001, 16'h1234, 4'b1011, 1'b0);

    // 3: all requesting; each grant held exactly 4 cycles in rr order.
    req = 4'b1111;
    for (int s = 1; s < 20; s++) begin
      int unsigned w;
      w = (s / 4) % 4;
      step();
      chk($sformatf("rot%0d.gnt", s), 32'(gnt), 32'(4'b0001 << w));
      chk($sformatf("rot%0d.hex", s), 32'({hex3, hex2, hex1, hex0}), 32'(d_tab[w]));
      chk($sformatf("rot%0d.dp", s), 32'(dp_out), 32'(p_tab[w]));
    end

    // 4: early drop hands over immediately and the new grant gets a full dwell.
    req = 4'b0001;
    step();
    chk("drop.g0a", 32'(gnt), 32'(4'b0001));
    req = 4'b0011;
    step();
    chk("drop.g0b", 32'(gnt), 32'(4'b0001));
    req = 4'b0010;
    step();
    chk_all("drop.sw", 4'b0010, 16'h5678, 4'b0111, 1'b0);
    req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reload%0d", i), 32'(gnt), 32'(4'b0010));
    end
    step();
    chk("reload.exp", 32'(gnt), 32'(4'b0001));

    // 5: lone requester keeps grant past dwell; data change shows after one edge.
    req = 4'b0100;
    step();
    chk_all("lone", 4'b0100, 16'h9abc, 4'b1101, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("lone%0d", i), 32'(gnt), 32'(4'b0100));
    end
    data2 = 16'h4321;
    #1;
    chk("live.old", 32'({hex3, hex2, hex1, hex0}), 32'(16'h9abc));
    step();
    chk("live.new", 32'({hex3, hex2, hex1, hex0}), 32'(16'h4321));

    // 6: async reset mid-show, then pointer back at 3 so requester 0 wins.
    req = 4'b1000;
    step();
    chk_all("g3", 4'b1000, 16'hdef0, 4'b1110, 1'b0);
    step();
    #2 rst_ni = 1'b0;
    #1;
    chk_all("midrst", 4'b0000, 16'h0000, 4'b1111, 1'b1);
    req = 4'b1001;
    step();
    chk_all("rsthold", 4'b0000, 16'h0000, 4'b1111, 1'b1);
    rst_ni = 1'b1;
    step();
    chk_all("postrst", 4'b0001, 16'h1234, 4'b1011, 1'b0);

    // Release all requests: back to blank values.
    req = 4'b0000;
    step();
    chk_all("toidle", 4'b0000, 16'h0000, 4'b1111, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
